// File: rtl/idct_pkg.sv
// Shared definitions for the IDCT front end.
//   COEF_W_DEF   : default coefficient width (two's complement)
//   bank_state_t : life cycle of one ping-pong bank
//   ZIGZAG       : scan index -> raster index (row*8 + col), JPEG/MPEG order
//   zz_raster()  : table lookup helper
package idct_pkg;

  localparam int COEF_W_DEF = 12;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  localparam logic [5:0] ZIGZAG [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  function automatic logic [5:0] zz_raster(input logic [5:0] idx);
    return ZIGZAG[idx];
  endfunction

endpackage

// File: rtl/zz_bank.sv
// One 64 x COEF_W coefficient bank, raster addressed.
//   clock, reset : clock and asynchronous active-high clear
//   clr          : synchronous clear of all 64 entries
//   we/waddr/wdata : single-entry write, raster address
//   row/rdata    : combinational read of one 8-entry row, column 0 at LSBs
module zz_bank
  import idct_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     we,
  input  logic [5:0]               waddr,
  input  logic signed [COEF_W-1:0] wdata,
  input  logic [2:0]               row,
  output logic [8*COEF_W-1:0]      rdata
);

  logic signed [COEF_W-1:0] mem [64];

  // Clearing on release is what provides the zero fill for an early
  // end-of-block: entries never written for the next block read back as 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < 8; c++) begin
      rdata[c*COEF_W +: COEF_W] = mem[{row, 3'(c)}];
    end
  end

endmodule

// File: rtl/zigzag_row_assembler.sv
// Un-zigzags a stream of dequantised coefficients (one per beat, scan order)
// into 8x8 raster blocks and emits each block as 8 packed row beats.
// Two banks are used ping-pong so one block fills while the other drains.
//   clock, reset        : clock, asynchronous active-high reset
//   slave_tdata/tvalid/tlast/tready : coefficient input, tlast = end-of-block
//   master_tdata/tvalid/tready/tlast : row output, column c at [c*COEF_W +: COEF_W],
//                          tlast on row 7
//   err_tlast           : one-cycle pulse when a block hit 64 coefficients
//                          without tlast (block is still closed and emitted)
module zigzag_row_assembler
  import idct_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [COEF_W-1:0] slave_tdata,
  input  logic                     slave_tvalid,
  input  logic                     slave_tlast,
  output logic                     slave_tready,
  output logic [COEF_W*8-1:0]      master_tdata,
  output logic                     master_tvalid,
  input  logic                     master_tready,
  output logic                     master_tlast,
  output logic                     err_tlast
);

  bank_state_t state   [2];
  bank_state_t state_n [2];
  logic [5:0]  widx;
  logic        wbank;
  logic        rbank;
  logic [2:0]  row;
  logic        err_q;

  logic        wr_open;
  logic        accept;
  logic        close;
  logic        miss;
  logic        rd_valid;
  logic        take;
  logic        release_bank;

  logic [COEF_W*8-1:0] rdata [2];

  // Write side: the write bank only accepts while it is not holding a closed
  // block. Gating with reset keeps tready low for the whole reset interval.
  assign wr_open = (state[wbank] == BANK_EMPTY) || (state[wbank] == BANK_FILLING);
  assign slave_tready = wr_open && !reset;
  assign accept = slave_tvalid && slave_tready;
  assign close  = accept && (slave_tlast || (widx == 6'd63));
  assign miss   = accept && !slave_tlast && (widx == 6'd63);

  // Read side: a bank is presentable from the cycle after it closes.
  assign rd_valid     = (state[rbank] == BANK_FULL) || (state[rbank] == BANK_DRAINING);
  assign take         = rd_valid && master_tready;
  assign release_bank = take && (row == 3'd7);

  assign master_tvalid = rd_valid;
  assign master_tlast  = rd_valid && (row == 3'd7);
  assign master_tdata  = rd_valid ? rdata[rbank] : '0;
  assign err_tlast     = err_q;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    zz_bank #(.COEF_W(COEF_W)) u_bank (
      .clock (clock),
      .reset (reset),
      .clr   (release_bank && (rbank == 1'(b))),
      .we    (accept && (wbank == 1'(b))),
      .waddr (zz_raster(widx)),
      .wdata (slave_tdata),
      .row   (row),
      .rdata (rdata[b])
    );
  end

  // Bank state machines. A write and a read can touch the same cycle only on
  // different banks: the writer needs EMPTY/FILLING, the reader FULL/DRAINING.
  always_comb begin
    state_n[0] = state[0];
    state_n[1] = state[1];
    if (accept) begin
      state_n[wbank] = close ? BANK_FULL : BANK_FILLING;
    end
    if (take) begin
      state_n[rbank] = (row == 3'd7) ? BANK_EMPTY : BANK_DRAINING;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state[0] <= BANK_EMPTY;
      state[1] <= BANK_EMPTY;
    end else begin
      state[0] <= state_n[0];
      state[1] <= state_n[1];
    end
  end

  // Pointers and the error pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      widx  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      row   <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        widx <= close ? 6'd0 : widx + 6'd1;
      end
      if (close) begin
        wbank <= ~wbank;
      end
      if (take) begin
        row <= (row == 3'd7) ? 3'd0 : row + 3'd1;
      end
      if (release_bank) begin
        rbank <= ~rbank;
      end
      err_q <= miss;
    end
  end

endmodule

// File: tb/tb_zigzag_row_assembler.sv
module tb_zigzag_row_assembler;
  localparam int W = 12;
  localparam int RW = 8 * W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  slave_tdata = '0;
  logic          slave_tvalid = 1'b0;
  logic          slave_tlast = 1'b0;
  logic          slave_tready;
  logic [RW-1:0] master_tdata;
  logic          master_tvalid;
  logic          master_tready = 1'b0;
  logic          master_tlast;
  logic          err_tlast;

  always #5 clock = ~clock;

  zigzag_row_assembler #(.COEF_W(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .slave_tdata  (slave_tdata),
    .slave_tvalid (slave_tvalid),
    .slave_tlast  (slave_tlast),
    .slave_tready (slave_tready),
    .master_tdata (master_tdata),
    .master_tvalid(master_tvalid),
    .master_tready(master_tready),
    .master_tlast (master_tlast),
    .err_tlast    (err_tlast)
  );

  int total = 0;
  int bad = 0;

  // Reference model state
  int            scan2raster [64];
  logic [W-1:0]  blk [64];
  int            cnt = 0;
  logic [RW-1:0] expq [$];
  logic [RW-1:0] seen [$];
  bit            err_exp = 0;
  int            acc_cnt = 0;
  int            err_seen = 0;
  bit            stall_prev = 0;
  logic [RW-1:0] stall_data = '0;
  bit            rnd_on = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] row8(input int c0, input int c1, input int c2, input int c3,
                                         input int c4, input int c5, input int c6, input int c7);
    logic [RW-1:0] r;
    int a [8];
    a = '{c0, c1, c2, c3, c4, c5, c6, c7};
    r = '0;
    for (int i = 0; i < 8; i++) r[i*W +: W] = W'(a[i]);
    return r;
  endfunction

  // Zigzag order derived by walking the anti-diagonals of the 8x8 block.
  task automatic build_zz();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin scan2raster[k] = r * 8 + (s - r); k++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin scan2raster[k] = r * 8 + (s - r); k++; end
      end
    end
  endtask

  // Compare process: outputs are checked against the model every cycle.
  always @(negedge clock) begin
    if (reset) begin
      expq.delete();
      cnt = 0;
      for (int i = 0; i < 64; i++) blk[i] = '0;
      err_exp = 0;
      stall_prev = 0;
    end else begin
      check("tvalid", master_tvalid, expq.size() != 0);
      check("slave_tready", slave_tready, ((expq.size() + 7) / 8) < 2);
      check("err_tlast", err_tlast, err_exp);
      if (err_tlast) err_seen++;
      if (stall_prev && master_tvalid) check("stall_hold", master_tdata, stall_data);
      if (master_tvalid && expq.size() != 0) begin
        check("row_data", master_tdata, expq[0]);
        check("row_tlast", master_tlast, (expq.size() % 8) == 1);
        if (master_tready) begin
          seen.push_back(master_tdata);
          void'(expq.pop_front());
        end
      end
      stall_prev = master_tvalid && !master_tready;
      stall_data = master_tdata;
      err_exp = 0;
      if (slave_tvalid && slave_tready) begin
        acc_cnt++;
        blk[scan2raster[cnt]] = slave_tdata;
        cnt++;
        if (slave_tlast || cnt == 64) begin
          for (int r = 0; r < 8; r++) begin
            logic [RW-1:0] rv;
            for (int c = 0; c < 8; c++) rv[c*W +: W] = blk[r*8 + c];
            expq.push_back(rv);
          end
          if (!slave_tlast) err_exp = 1;
          for (int i = 0; i < 64; i++) blk[i] = '0;
          cnt = 0;
        end
      end
    end
  end

  always @(posedge clock) begin
    if (rnd_on) begin
      #1;
      master_tready = 1'($urandom_range(0, 1));
    end
  end

  // Drivers (called shortly after a rising edge)
  task automatic send(input logic [W-1:0] d, input bit last);
    int guard;
    guard = 0;
    slave_tdata = d;
    slave_tlast = last;
    slave_tvalid = 1'b1;
    @(negedge clock);
    while (!slave_tready) begin
      guard++;
      if (guard > 3000) begin
        total++;
        bad++;
        $display("FAIL send_timeout: slave_tready stuck at %b expected 1", slave_tready);
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    slave_tvalid = 1'b0;
    slave_tlast = 1'b0;
  endtask

  // mode 0: v = i*mul + add ; tlast on beat n-1 if tl
  task automatic send_block(input int n, input int mul, input int add, input bit tl);
    for (int i = 0; i < n; i++) send(W'(i * mul + add), tl && (i == n - 1));
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    forever begin
      @(posedge clock);
      #1;
      if (expq.size() == 0 && !master_tvalid) break;
      guard++;
      if (guard > 3000) begin
        total++;
        bad++;
        $display("FAIL drain_timeout: %0d rows still expected, tvalid=%b", expq.size(), master_tvalid);
        break;
      end
    end
  endtask

  initial begin
    build_zz();
    // Reset state
    #2;
    check("rst_slave_tready", slave_tready, 1'b0);
    check("rst_tvalid", master_tvalid, 1'b0);
    check("rst_tdata", master_tdata, '0);
    check("rst_tlast", master_tlast, 1'b0);
    check("rst_err", err_tlast, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_rst_tready", slave_tready, 1'b1);
    @(posedge clock);
    #1;

    // Ramp block
    master_tready = 1'b1;
    seen.delete();
    err_seen = 0;
    send_block(64, 1, 1, 1'b1);
    wait_drain();
    check("ramp_rows", seen.size(), 8);
    check("ramp_row0", seen[0], row8(1, 2, 6, 7, 15, 16, 28, 29));
    check("ramp_row7", seen[7], row8(36, 37, 49, 50, 58, 59, 63, 64));
    check("ramp_no_err", err_seen, 0);

    // DC-only early EOB, then a block of -1
    seen.delete();
    send(12'h064, 1'b1);
    send_block(64, 0, -1, 1'b1);
    wait_drain();
    check("dc_rows", seen.size(), 16);
    check("dc_row0", seen[0], row8(100, 0, 0, 0, 0, 0, 0, 0));
    check("dc_row1", seen[1], '0);
    check("dc_row7", seen[7], '0);
    check("neg_row0", seen[8], row8(-1, -1, -1, -1, -1, -1, -1, -1));
    check("neg_row7", seen[15], row8(-1, -1, -1, -1, -1, -1, -1, -1));

    // Backpressure: two blocks fill both banks, third stalls
    seen.delete();
    master_tready = 1'b0;
    begin
      int base;
      base = acc_cnt;
      send_block(64, 1, 1, 1'b1);
      send_block(64, 2, 2, 1'b1);
      fork
        send_block(64, 1, 101, 1'b1);
      join_none
      repeat (10) @(posedge clock);
      #1;
      check("bp_accepted", acc_cnt - base, 128);
      check("bp_full_tready", slave_tready, 1'b0);
      master_tready = 1'b1;
      repeat (8) @(posedge clock);
      #1 master_tready = 1'b0;
      check("bp_tready_back", slave_tready, 1'b1);
      repeat (3) @(posedge clock);
      #1 master_tready = 1'b1;
      wait fork;
    end
    wait_drain();
    check("bp_rows", seen.size(), 24);
    check("bp_blk1_row0", seen[0], row8(1, 2, 6, 7, 15, 16, 28, 29));
    check("bp_blk2_row0", seen[8], row8(2, 4, 12, 14, 30, 32, 56, 58));
    check("bp_blk3_row0", seen[16], row8(101, 102, 106, 107, 115, 116, 128, 129));

    // Missing tlast
    seen.delete();
    err_seen = 0;
    send_block(64, 1, 1, 1'b0);
    send(12'd5, 1'b1);
    wait_drain();
    check("miss_err_pulses", err_seen, 1);
    check("miss_blk_row7", seen[7], row8(36, 37, 49, 50, 58, 59, 63, 64));
    check("miss_next_row0", seen[8], row8(5, 0, 0, 0, 0, 0, 0, 0));

    // Random output stalls
    seen.delete();
    rnd_on = 1;
    send_block(64, 1, 1, 1'b1);
    send(12'd7, 1'b1);
    send_block(64, 3, 3, 1'b1);
    wait_drain();
    rnd_on = 0;
    @(posedge clock);
    #2 master_tready = 1'b1;
    check("stall_rows", seen.size(), 24);
    check("stall_row0", seen[0], row8(1, 2, 6, 7, 15, 16, 28, 29));
    check("stall_dc", seen[8], row8(7, 0, 0, 0, 0, 0, 0, 0));
    check("stall_row7", seen[23], row8(108, 111, 147, 150, 174, 177, 189, 192));

    // Asynchronous reset mid-block
    @(posedge clock);
    #1 master_tready = 1'b0;
    send_block(64, 5, 5, 1'b1);
    send_block(30, 5, 7, 1'b0);
    master_tready = 1'b1;
    repeat (3) @(posedge clock);
    #1 master_tready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_tvalid", master_tvalid, 1'b0);
    check("arst_tdata", master_tdata, '0);
    check("arst_tlast", master_tlast, 1'b0);
    check("arst_tready", slave_tready, 1'b0);
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1 master_tready = 1'b1;
    seen.delete();
    send_block(64, 1, 1, 1'b1);
    wait_drain();
    check("arst_rows", seen.size(), 8);
    check("arst_row0", seen[0], row8(1, 2, 6, 7, 15, 16, 28, 29));
    check("arst_row7", seen[7], row8(36, 37, 49, 50, 58, 59, 63, 64));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/zigzag_row_assembler.md
Name: zigzag_row_assembler

Overview:
- Upstream neighbour of the wide AXI-stream IDCT wrapper.
- Accepts dequantised DCT coefficients one per beat, in zigzag scan order, on an AXI-stream slave.
- Un-zigzags them into an 8x8 raster block and emits the block as 8 row beats of 8 packed coefficients. This matches the wrapper's COEF_W*8 slave input.
- Ping-pong buffered, so one block can be filled while the previous one drains.

Parameters:
- COEF_W, 12, coefficient width in bits (two's complement), equal to the IDCT input width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- slave_tdata  in  COEF_W  one coefficient, zigzag order.
- slave_tvalid  in  1  input beat valid.
- slave_tlast  in  1  last non-zero coefficient of the block (end-of-block).
- slave_tready  out  1  input beat accepted when high with tvalid.
- master_tdata  out  COEF_W*8  one raster row; column c at bits [c*COEF_W +: COEF_W], column 0 at the LSBs.
- master_tvalid  out  1  row beat valid.
- master_tready  in  1  downstream ready.
- master_tlast  out  1  high on row 7 of a block.
- err_tlast  out  1  one-cycle pulse when a block reaches 64 coefficients without tlast.

Behaviour:
- Reset is asynchronous, active-high.
  - Both banks are cleared to 0; bank states go to EMPTY.
  - Write index is 0; write bank is 0; read bank is 0; row counter is 0.
  - Outputs: slave_tready=0 while reset is asserted, 1 from the first cycle after deassertion. master_tvalid=0, master_tlast=0, master_tdata=0, err_tlast=0.
- Storage: two banks, each 64 x COEF_W. Each bank has state EMPTY, FILLING, FULL or DRAINING.
- Write side:
  - slave_tready = (write bank state is EMPTY or FILLING).
  - On an accepted beat: bank[ZIGZAG[idx]] <= slave_tdata, idx <= idx+1, and the state becomes FILLING.
  - The block closes on an accepted beat with slave_tlast=1, or when idx==63.
  - On close: the state becomes FULL, idx <= 0 and the write bank toggles.
  - Unwritten entries stay 0; this gives early-EOB zero fill.
  - tlast on the beat at idx==63 is normal.
  - No tlast at idx==63: the block closes anyway and err_tlast pulses for 1 cycle.
  - A beat arriving after an early tlast starts the next block.
- Read side:
  - master_tvalid = (read bank state is FULL or DRAINING).
  - master_tdata = row `row` of the read bank when valid, else 0.
  - master_tlast = valid and row==7.
  - On master_tvalid && master_tready: row <= row+1, and the state becomes DRAINING.
  - On acceptance at row==7: all 64 entries of the bank are cleared to 0, the state becomes EMPTY, row <= 0 and the read bank toggles.
  - master_tdata/master_tvalid must stay stable while master_tready=0.
- Latency:
  - The closing beat is accepted on edge t. master_tvalid is high in the cycle after edge t if the read bank was idle.
  - Row k of that block is presentable no earlier than k cycles after that.
- Simultaneous events:
  - The read side may release bank B on the same edge on which the write side is stalled waiting for B. slave_tready then rises the next cycle.
  - A write to bank A and a read from bank B in the same cycle are independent.
  - Close and release of the same bank cannot coincide, because the states exclude it.
- Full condition: both banks FULL or DRAINING gives slave_tready=0. This holds 128 coefficients maximum.
- No arithmetic: coefficients pass bit-exact, with sign preserved.

Decomposition:
- Shared package idct_pkg:
  - COEF_W default.
  - ZIGZAG: a 64-entry constant mapping scan index to raster index, standard JPEG/MPEG order 0,1,8,16,9,2,3,10,17,24,...
  - Bank-state encoding EMPTY/FILLING/FULL/DRAINING.
- One sub-module, zz_bank: a single 64 x COEF_W bank.
  - Write port with raster address.
  - 8-entry row read port.
  - Synchronous clear-all.
  - Instantiated twice.

Test Plan:
- Ramp block: 64 beats with value = scan index + 1, tlast on beat 63, master_tready=1.
  - Row 0 = {1,2,6,7,15,16,28,29}, column 0 first.
  - Row 7 = {36,37,49,50,58,59,63,64}.
  - master_tlast only on row 7; err_tlast never asserted.
- DC-only early EOB: a single beat of 12'h064 with tlast.
  - Row 0 = {100,0,0,0,0,0,0,0}, rows 1-7 all 0.
  - The next block, 64 beats of -1 (12'hFFF), yields all-0xFFF rows.
- Backpressure: master_tready=0, then stream 3 blocks.
  - Exactly 128 beats are accepted, then slave_tready=0.
  - After 8 row handshakes on the master side, slave_tready returns to 1 on the next cycle.
  - Output order is block 1 then block 2.
- Missing tlast: 64 beats with tlast=0.
  - err_tlast pulses 1 cycle after the 64th beat.
  - The block is emitted normally.
  - Beat 65 starts a new block.
- Stall stability: toggle master_tready randomly mid-block.
  - tdata/tvalid hold constant while tready=0.
  - No row is lost or duplicated.
- Async reset mid-block: assert reset after 30 input beats and 3 output rows, off a clock edge.
  - Outputs are 0 immediately.
  - After release, a fresh ramp block produces the exact ramp result, with no residue from the aborted blocks.
